// File: rtl/int_seq_multi.sv
// Interrupt sequencer for the k6502 core: arbitrates reset, an edge-triggered NMI and
// IRQ_CH maskable level IRQs at instruction boundaries and supplies the vector low byte.
module int_seq_multi #(
    parameter int          IRQ_CH      = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int          VECTORED    = 0,
    parameter logic [7:0]  VEC_BASE    = 8'hEE,
    localparam int         IW          = (IRQ_CH > 1) ? $clog2(IRQ_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync,
    input  logic              i_flag,
    input  logic              nmi_n,
    input  logic [IRQ_CH-1:0] irq_n,
    input  logic [IRQ_CH-1:0] irq_mask,
    input  logic              ack,
    output logic              rst,
    output logic              nmi,
    output logic              irq,
    output logic [IW-1:0]     irq_id,
    output logic [7:0]        vec_lo,
    output logic [IRQ_CH-1:0] pending
);

    typedef enum logic [1:0] {S_RST, S_IDLE, S_NMI, S_IRQ} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IRQ_CH:0]   r_sync [SYNC_STAGES];
    logic [IRQ_CH:0]   w_pins;
    logic [IRQ_CH:0]   w_sync;
    logic              w_nmi_s;
    logic              w_nmi_edge;
    logic              r_nmi_prev;
    logic              r_nmi_pend;
    logic              w_take_irq;
    logic [IW-1:0]     w_low_id;
    logic [7:0]        w_irq_vec;
    logic [IW-1:0]     r_irq_id;
    logic [7:0]        r_vec_lo;

    // NMI rides in the top bit so one chain synchronises every pin.
    assign w_pins = {nmi_n, irq_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '1;
        end else begin
            r_sync[0] <= w_pins;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_nmi_s    = w_sync[IRQ_CH];
    assign pending    = ~w_sync[IRQ_CH-1:0] & irq_mask;
    assign w_nmi_edge = r_nmi_prev & ~w_nmi_s;

    // A fresh edge coinciding with the NMI ack must not be lost, so set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nmi_prev <= 1'b1;
            r_nmi_pend <= 1'b0;
        end else begin
            r_nmi_prev <= w_nmi_s;
            if (w_nmi_edge)
                r_nmi_pend <= 1'b1;
            else if (ack && r_state == S_NMI)
                r_nmi_pend <= 1'b0;
        end
    end

    always_comb begin
        w_low_id = '0;
        for (int k = IRQ_CH - 1; k >= 0; k--) begin
            if (pending[k]) w_low_id = IW'(k);
        end
    end

    assign w_irq_vec  = (VECTORED != 0) ? (VEC_BASE - (8'(w_low_id) << 1)) : 8'hFE;
    assign w_take_irq = (r_state == S_IDLE) && sync && !r_nmi_pend && !i_flag && (|pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RST;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RST:   if (ack) w_state_next = S_IDLE;
            S_IDLE: begin
                if (sync && r_nmi_pend) w_state_next = S_NMI;
                else if (w_take_irq)    w_state_next = S_IRQ;
            end
            S_NMI:   if (ack) w_state_next = S_IDLE;
            S_IRQ:   if (ack) w_state_next = S_IDLE;
            default: w_state_next = S_RST;
        endcase
    end

    // Channel and vector are captured on entry and frozen for the whole sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_id <= '0;
            r_vec_lo <= 8'hFC;
        end else if (w_take_irq) begin
            r_irq_id <= w_low_id;
            r_vec_lo <= w_irq_vec;
        end else if (r_state == S_IDLE && w_state_next == S_NMI) begin
            r_vec_lo <= 8'hFA;
        end
    end

    always_comb begin
        rst    = (r_state == S_RST);
        nmi    = (r_state == S_NMI);
        irq    = (r_state == S_IRQ);
        irq_id = r_irq_id;
        vec_lo = r_vec_lo;
    end

endmodule

// File: tb/tb_int_seq_multi.sv
// Randomised and directed bench for int_seq_multi with a cycle-level reference model
// feeding a scoreboard queue that a separate monitor drains.
module tb_int_seq_multi;

    localparam int         IRQ_CH   = 4;
    localparam int         SS       = 2;
    localparam logic [7:0] VEC_BASE = 8'hEE;

    logic       clk = 1'b0;
    logic       rst_n, sync, i_flag, nmi_n, ack;
    logic [3:0] irq_n, irq_mask;
    logic       rst, nmi, irq;
    logic [1:0] irq_id;
    logic [7:0] vec_lo;
    logic [3:0] pending;

    int unsigned passed = 0;
    int unsigned total  = 0;

    int_seq_multi #(.IRQ_CH(IRQ_CH), .SYNC_STAGES(SS), .VECTORED(1), .VEC_BASE(VEC_BASE)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .i_flag(i_flag), .nmi_n(nmi_n),
        .irq_n(irq_n), .irq_mask(irq_mask), .ack(ack), .rst(rst), .nmi(nmi), .irq(irq),
        .irq_id(irq_id), .vec_lo(vec_lo), .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=reset 1=idle 2=nmi 3=irq; pins seen through an SS-deep delay line.
    int         m_mode = 0;
    logic       m_pend = 1'b0;
    logic       m_prev = 1'b1;
    logic [4:0] m_hist [SS];
    logic [1:0] m_id = 2'd0;
    logic [7:0] m_vec = 8'hFC;
    logic [16:0] exp_q [$];

    initial for (int k = 0; k < SS; k++) m_hist[k] = 5'h1F;

    always @(posedge clk) begin
        logic [4:0] s_old;
        logic [3:0] pbits;
        logic       fell, clr;
        if (!rst_n) begin
            m_mode = 0; m_pend = 1'b0; m_prev = 1'b1; m_id = 2'd0; m_vec = 8'hFC;
            for (int k = 0; k < SS; k++) m_hist[k] = 5'h1F;
        end else begin
            s_old = m_hist[SS-1];
            pbits = ~s_old[3:0] & irq_mask;
            fell  = m_prev && !s_old[4];
            clr   = ack && (m_mode == 2);
            if (m_mode == 1) begin
                if (sync && m_pend) begin
                    m_mode = 2; m_vec = 8'hFA;
                end else if (sync && !i_flag && pbits != 4'd0) begin
                    for (int k = 3; k >= 0; k--) if (pbits[k]) m_id = 2'(k);
                    m_vec = VEC_BASE - 8'(2 * m_id);
                    m_mode = 3;
                end
            end else if (ack) begin
                m_mode = 1;
            end
            m_pend = fell || (m_pend && !clr);
            m_prev = s_old[4];
            for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = {nmi_n, irq_n};
        end
        exp_q.push_back({m_mode == 0, m_mode == 2, m_mode == 3, m_id, m_vec,
                         ~m_hist[SS-1][3:0] & irq_mask});
    end

    always begin
        logic [16:0] e, a;
        @(posedge clk);
        #1;
        total++;
        a = {rst, nmi, irq, irq_id, vec_lo, pending};
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty t=%0t got=%h", $time, a);
        end else begin
            e = exp_q.pop_front();
            if (a === e) passed++;
            else $display("FAIL cycle t=%0t got rst/nmi/irq=%b%b%b id=%0d vec=%h pend=%b want rst/nmi/irq=%b%b%b id=%0d vec=%h pend=%b",
                          $time, a[16], a[15], a[14], a[13:12], a[11:4], a[3:0],
                          e[16], e[15], e[14], e[13:12], e[11:4], e[3:0]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sync();
        sync = 1'b1; cyc(1); sync = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; cyc(1); ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sync = 1'b0; i_flag = 1'b0; nmi_n = 1'b1; ack = 1'b0;
        irq_n = 4'hF; irq_mask = 4'hF;
        cyc(3);
        rst_n = 1'b1;
        cyc(2); pulse_sync(); cyc(2);
        pulse_ack(); pulse_sync(); cyc(2);

        nmi_n = 1'b0; cyc(4); pulse_sync(); cyc(2); pulse_ack();
        repeat (3) begin pulse_sync(); cyc(1); end
        nmi_n = 1'b1; cyc(3);

        irq_n = 4'b0011; cyc(3); pulse_sync(); cyc(1);
        irq_n = 4'hF; cyc(4); pulse_ack(); cyc(3);

        i_flag = 1'b1; irq_n = 4'b1110; cyc(3);
        repeat (10) begin pulse_sync(); cyc(1); end
        i_flag = 1'b0; irq_mask = 4'b1110;
        repeat (10) begin pulse_sync(); cyc(1); end
        irq_mask = 4'hF; cyc(1); pulse_sync(); cyc(2); pulse_ack(); cyc(1);

        pulse_sync(); cyc(1);
        nmi_n = 1'b0; cyc(4); nmi_n = 1'b1; cyc(3);
        pulse_ack(); cyc(1); pulse_sync(); cyc(2);
        nmi_n = 1'b0; cyc(2); pulse_ack(); pulse_sync(); cyc(2);

        rst_n = 1'b0;
        #1;
        total++;
        if ({rst, nmi, irq, vec_lo} === {3'b100, 8'hFC}) passed++;
        else $display("FAIL async_reset got rst/nmi/irq=%b%b%b vec=%h want 100 vec=fc", rst, nmi, irq, vec_lo);
        cyc(2);
        rst_n = 1'b1; nmi_n = 1'b1; irq_n = 4'hF; cyc(3);
        pulse_sync(); cyc(1); pulse_ack(); cyc(2);

        for (int i = 0; i < 600; i++) begin
            sync   = ($urandom_range(0, 2) == 0);
            ack    = ($urandom_range(0, 4) == 0);
            i_flag = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) irq_mask = 4'($urandom);
            if ($urandom_range(0, 7) == 0)  irq_n = 4'($urandom);
            if ($urandom_range(0, 9) == 0)  nmi_n = ~nmi_n;
            rst_n = ($urandom_range(0, 200) != 0);
            cyc(1);
        end
        sync = 1'b0; ack = 1'b0; rst_n = 1'b1;
        cyc(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
